input_port_vc_credit: RTL and testbench
=======================================

Name: input_port_vc_credit

Overview:
- Single router input port with VC_NUM virtual channels.
- Each VC has its own BUFFER_SIZE flit FIFO, a per-VC packet state machine, and XY route computation.
- Downstream flow control is selectable per instance: on/off with hysteresis thresholds, or credit return.
- Sits between the link receiver and the VC allocator, switch allocator and crossbar; instantiated PORT_NUM times by the input block.

Parameters:
- VC_NUM, 2: number of virtual channels; VC id width VC_SIZE = $clog2(VC_NUM).
- BUFFER_SIZE, 8: per-VC FIFO depth; power of two, at least 2.
- X_CURRENT, MESH_SIZE_X/2: router X coordinate.
- Y_CURRENT, MESH_SIZE_Y/2: router Y coordinate.
- FLOW_MODE, 0: 0 = on/off, 1 = credit.
- OFF_THRESH, BUFFER_SIZE-2: occupancy at or above which on_off_o[v] drops (on/off mode only).
- ON_THRESH, BUFFER_SIZE/2: occupancy at or below which on_off_o[v] rises (on/off mode only); must be < OFF_THRESH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- data_i  in  flit_t  incoming flit; uses fields flit_label, vc_id, head_data.x_dest, head_data.y_dest.
- valid_flit_i  in  1  data_i valid this cycle.
- va_new_vc_i  in  [VC_NUM-1:0][VC_SIZE-1:0]  downstream VC granted per local VC.
- va_valid_i  in  VC_NUM  VA grant strobe per local VC.
- sa_sel_vc_i  in  VC_NUM  one-hot local VC chosen by SA.
- sa_valid_i  in  1  SA grant valid.
- xb_flit_o  out  flit_t  flit to crossbar, vc_id rewritten to downstream VC.
- xb_valid_o  out  1  xb_flit_o valid.
- va_request_o  out  VC_NUM  VA request per VC.
- sa_request_o  out  VC_NUM  SA request per VC.
- sa_downstream_vc_o  out  [VC_NUM-1:0][VC_SIZE-1:0]  latched downstream VC per VC.
- out_port_o  out  port_t [VC_NUM-1:0]  latched route per VC.
- on_off_o  out  VC_NUM  on/off back-pressure to upstream.
- credit_valid_o  out  1  one-cycle credit return pulse.
- credit_vc_o  out  VC_SIZE  VC the credit refers to.
- is_allocatable_vc_o  out  VC_NUM  VC is IDLE and its FIFO is empty.
- error_o  out  VC_NUM  sticky per-VC error.

Behaviour:
- Reset (async, rst=1): all FIFOs empty; all states IDLE; out_port_o=LOCAL; sa_downstream_vc_o=0; xb_valid_o=0; xb_flit_o=0; credit_valid_o=0; credit_vc_o=0; on_off_o all 1; error_o=0; is_allocatable_vc_o all 1. Reset mid-packet discards buffered flits; no credits are issued for them.
- Push: valid_flit_i and data_i.vc_id==v writes FIFO v. If FIFO v is full and not popped in the same cycle, the flit is dropped and error_o[v] is set.
- Push and pop on the same full FIFO in one cycle is legal; count is unchanged.
- Pop: sa_valid_i and sa_sel_vc_i[v] pops FIFO v.
  - Pop of an empty VC, or of a VC not in ACTIVE: ignored, error_o[v] set.
  - sa_sel_vc_i not one-hot while sa_valid_i=1: no pop, error_o set for every selected VC.
- Per-VC FSM:
  - IDLE -> VA when the FIFO is non-empty and the head is HEAD or HEADTAIL. On this transition out_port_o[v] latches the XY route from the head:
    - x_dest > X_CURRENT: EAST.
    - x_dest < X_CURRENT: WEST.
    - otherwise y_dest < Y_CURRENT: NORTH; y_dest > Y_CURRENT: SOUTH; equal: LOCAL.
  - IDLE with a BODY or TAIL at the head: error_o[v] set, flit discarded (popped internally, credit still returned), stay IDLE.
  - VA: va_request_o[v]=1. va_valid_i[v] latches va_new_vc_i[v] into sa_downstream_vc_o[v] and moves to ACTIVE the next cycle.
  - ACTIVE: sa_request_o[v] = FIFO v non-empty. Popping a TAIL or HEADTAIL returns to IDLE the next cycle. A following head then enters VA one cycle after that (no same-cycle chaining).
  - va_valid_i[v] outside VA: ignored.
- Crossbar output is registered, latency 1. A flit popped in cycle t appears on xb_flit_o at t+1 with xb_valid_o=1 and vc_id = sa_downstream_vc_o[v]; all other fields are unchanged. xb_valid_o=0 when there is no pop.
- Credit mode (FLOW_MODE=1): every FIFO pop, including internal discards, gives credit_valid_o=1 and credit_vc_o=v at t+1. on_off_o is held at all 1s.
- On/off mode (FLOW_MODE=0): on_off_o[v] is registered with hysteresis on post-update occupancy: cleared when occupancy >= OFF_THRESH, set when occupancy <= ON_THRESH, otherwise held. credit_valid_o is held at 0.
- Occupancy counters are $clog2(BUFFER_SIZE)+1 bits wide; read/write pointers wrap modulo BUFFER_SIZE.
- error_o bits clear only on reset.

Test Plan:
- HEADTAIL, vc_id=1, x_dest=X+1 -> VC1 moves to VA, out_port_o[1]=EAST, va_request_o=2'b10. va_valid_i[1] with new vc 0 -> sa_request_o[1]=1. SA pop -> next cycle xb_flit_o.vc_id=0, xb_valid_o=1, credit_valid_o=1, credit_vc_o=1, VC1 back to IDLE.
- 4-flit packet on VC0 (HEAD, BODY, BODY, TAIL) with x_dest=X, y_dest<Y -> NORTH. Four back-to-back pops -> xb_valid_o high for 4 consecutive cycles; is_allocatable_vc_o[0]=1 the cycle after the tail pop.
- FLOW_MODE=0, BUFFER_SIZE=8: push 6 flits to VC0 -> on_off_o[0]=0. Pop 1 -> still 0. Pop down to 4 -> 1.
- Push 9 flits to VC1 with no pops -> ninth dropped, error_o[1]=1, occupancy 8. On a full FIFO, simultaneous push and pop -> no error, occupancy 8.
- BODY flit arrives first on VC0 -> error_o[0]=1, credit_valid_o pulses once, VC0 stays IDLE. SA pop of empty VC1 -> error_o[1]=1, xb_valid_o=0.
- Interleaved packets on VC0 and VC1, rst asserted mid-stream -> all outputs go to reset values immediately (async); no credits after reset.

Source files
------------

// File: rtl/input_port_vc_credit.sv
// ---------------------------------------------------------------------------
// noc_params: shared NoC types for the router input port.
//   flit_t  : label, VC id and head routing data (x_dest, y_dest, payload)
//   port_t  : router output direction
// input_port_vc_credit: one router input port with VC_NUM virtual channels.
//   Each VC has a BUFFER_SIZE flit FIFO, a packet FSM (IDLE/VA/ACTIVE) and
//   XY route computation. Upstream back-pressure is on/off with hysteresis
//   (FLOW_MODE=0) or one credit per popped flit (FLOW_MODE=1).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   data_i, valid_flit_i      incoming flit from the link receiver
//   va_new_vc_i, va_valid_i   VC allocator grants per local VC
//   sa_sel_vc_i, sa_valid_i   switch allocator grant (one-hot local VC)
//   xb_flit_o, xb_valid_o     registered flit to the crossbar
//   va_request_o              VC allocation requests
//   sa_request_o              switch allocation requests
//   sa_downstream_vc_o        downstream VC latched per local VC
//   out_port_o                route latched per local VC
//   on_off_o                  on/off back-pressure per VC
//   credit_valid_o/credit_vc_o credit return pulse and its VC
//   is_allocatable_vc_o       VC idle with an empty FIFO
//   error_o                   sticky per-VC protocol error
// ---------------------------------------------------------------------------
package noc_params;
  localparam int MESH_SIZE_X       = 4;
  localparam int MESH_SIZE_Y       = 4;
  localparam int DEST_ADDR_SIZE_X  = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y  = $clog2(MESH_SIZE_Y);
  localparam int NOC_VC_NUM        = 2;
  localparam int NOC_VC_SIZE       = $clog2(NOC_VC_NUM);
  localparam int HEAD_PAYLOAD_SIZE = 8;

  typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;
  typedef enum logic [2:0] {LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, WEST = 3'd3, EAST = 3'd4} port_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef struct packed {
    flit_label_t            flit_label;
    logic [NOC_VC_SIZE-1:0] vc_id;
    head_data_t             head_data;
  } flit_t;
endpackage

module input_port_vc_credit
  import noc_params::*;
#(
  parameter int VC_NUM      = NOC_VC_NUM,
  parameter int BUFFER_SIZE = 8,
  parameter int X_CURRENT   = MESH_SIZE_X / 2,
  parameter int Y_CURRENT   = MESH_SIZE_Y / 2,
  parameter int FLOW_MODE   = 0,
  parameter int OFF_THRESH  = BUFFER_SIZE - 2,
  parameter int ON_THRESH   = BUFFER_SIZE / 2,
  localparam int VC_SIZE    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  flit_t                            data_i,
  input  logic                             valid_flit_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]   va_new_vc_i,
  input  logic [VC_NUM-1:0]                va_valid_i,
  input  logic [VC_NUM-1:0]                sa_sel_vc_i,
  input  logic                             sa_valid_i,
  output flit_t                            xb_flit_o,
  output logic                             xb_valid_o,
  output logic [VC_NUM-1:0]                va_request_o,
  output logic [VC_NUM-1:0]                sa_request_o,
  output logic [VC_NUM-1:0][VC_SIZE-1:0]   sa_downstream_vc_o,
  output port_t [VC_NUM-1:0]               out_port_o,
  output logic [VC_NUM-1:0]                on_off_o,
  output logic                             credit_valid_o,
  output logic [VC_SIZE-1:0]               credit_vc_o,
  output logic [VC_NUM-1:0]                is_allocatable_vc_o,
  output logic [VC_NUM-1:0]                error_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, VA = 2'd1, ACTIVE = 2'd2} vc_state_t;

  // Registered state
  flit_t                          mem_q   [VC_NUM][BUFFER_SIZE];
  logic [PTR_W-1:0]               rdPtr_q [VC_NUM];
  logic [PTR_W-1:0]               wrPtr_q [VC_NUM];
  logic [CNT_W-1:0]               count_q [VC_NUM];
  vc_state_t                      state_q [VC_NUM];
  port_t [VC_NUM-1:0]             outPort_q;
  logic [VC_NUM-1:0][VC_SIZE-1:0] downVc_q;
  logic [VC_NUM-1:0]              onOff_q;
  logic [VC_NUM-1:0]              error_q;
  flit_t                          xbFlit_q;
  logic                           xbValid_q;
  logic                           creditValid_q;
  logic [VC_SIZE-1:0]             creditVc_q;

  // Next-state / decode
  logic [CNT_W-1:0]  count_d [VC_NUM];
  flit_t             headFlit [VC_NUM];
  flit_t             xbFlit_d;
  logic [VC_NUM-1:0] empty, full, push, pushOk, pushErr;
  logic [VC_NUM-1:0] saPop, saErr, discardReq, discard, pop, headIsStart;
  logic              saOneHot, anySaPop, anyPop;
  logic [VC_SIZE-1:0] popVc;

  // XY dimension-order routing: resolve X first, then Y.
  function automatic port_t xyRoute(input logic [DEST_ADDR_SIZE_X-1:0] xd,
                                    input logic [DEST_ADDR_SIZE_Y-1:0] yd);
    port_t r;
    if (int'(xd) > X_CURRENT)      r = EAST;
    else if (int'(xd) < X_CURRENT) r = WEST;
    else if (int'(yd) < Y_CURRENT) r = NORTH;
    else if (int'(yd) > Y_CURRENT) r = SOUTH;
    else                           r = LOCAL;
    return r;
  endfunction

  // Per-VC push/pop decode. At most one FIFO pops per cycle so a single
  // credit register suffices: an internal discard of a stray BODY/TAIL
  // yields to any SA pop, and concurrent discards go lowest VC first.
  // A deferred discard simply retries the following cycle.
  always_comb begin
    logic found;
    found    = 1'b0;
    saOneHot = (sa_sel_vc_i != '0) &&
               ((sa_sel_vc_i & (sa_sel_vc_i - VC_NUM'(1))) == '0);
    for (int v = 0; v < VC_NUM; v++) begin
      headFlit[v]    = mem_q[v][rdPtr_q[v]];
      empty[v]       = (count_q[v] == '0);
      full[v]        = (count_q[v] == CNT_W'(BUFFER_SIZE));
      push[v]        = valid_flit_i && (int'(data_i.vc_id) == v);
      headIsStart[v] = (headFlit[v].flit_label == HEAD) ||
                       (headFlit[v].flit_label == HEADTAIL);
      saPop[v]       = sa_valid_i && saOneHot && sa_sel_vc_i[v] &&
                       !empty[v] && (state_q[v] == ACTIVE);
      saErr[v]       = sa_valid_i && sa_sel_vc_i[v] &&
                       (!saOneHot || empty[v] || (state_q[v] != ACTIVE));
      discardReq[v]  = (state_q[v] == IDLE) && !empty[v] && !headIsStart[v];
    end
    anySaPop = |saPop;
    discard  = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (!anySaPop && discardReq[v] && !found) begin
        discard[v] = 1'b1;
        found      = 1'b1;
      end
    end
    pop    = saPop | discard;
    anyPop = |pop;
    popVc  = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (pop[v]) popVc = VC_SIZE'(v);
    end
    for (int v = 0; v < VC_NUM; v++) begin
      // A full FIFO still accepts a flit when it is popped in the same cycle.
      pushOk[v]  = push[v] && (!full[v] || pop[v]);
      pushErr[v] = push[v] && full[v] && !pop[v];
      count_d[v] = count_q[v] + CNT_W'(pushOk[v]) - CNT_W'(pop[v]);
    end
    xbFlit_d       = headFlit[popVc];
    xbFlit_d.vc_id = NOC_VC_SIZE'(downVc_q[popVc]);
  end

  // Flit storage has no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (pushOk[v]) mem_q[v][wrPtr_q[v]] <= data_i;
    end
  end

  // FIFO bookkeeping, packet FSM, route/VC latches, errors and on/off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        rdPtr_q[v]   <= '0;
        wrPtr_q[v]   <= '0;
        count_q[v]   <= '0;
        state_q[v]   <= IDLE;
        outPort_q[v] <= LOCAL;
      end
      downVc_q <= '0;
      onOff_q  <= '1;
      error_q  <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (pushOk[v]) wrPtr_q[v] <= wrPtr_q[v] + PTR_W'(1);
        if (pop[v])    rdPtr_q[v] <= rdPtr_q[v] + PTR_W'(1);
        count_q[v] <= count_d[v];

        if (pushErr[v] || saErr[v] || discard[v]) error_q[v] <= 1'b1;

        case (state_q[v])
          IDLE: begin
            if (!empty[v] && headIsStart[v]) begin
              state_q[v]   <= VA;
              outPort_q[v] <= xyRoute(headFlit[v].head_data.x_dest,
                                      headFlit[v].head_data.y_dest);
            end
          end
          VA: begin
            if (va_valid_i[v]) begin
              downVc_q[v] <= va_new_vc_i[v];
              state_q[v]  <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (saPop[v] && ((headFlit[v].flit_label == TAIL) ||
                             (headFlit[v].flit_label == HEADTAIL)))
              state_q[v] <= IDLE;
          end
          default: state_q[v] <= IDLE;
        endcase

        // Hysteresis on post-update occupancy keeps on_off from chattering.
        if (FLOW_MODE != 0)                           onOff_q[v] <= 1'b1;
        else if (count_d[v] >= CNT_W'(OFF_THRESH))    onOff_q[v] <= 1'b0;
        else if (count_d[v] <= CNT_W'(ON_THRESH))     onOff_q[v] <= 1'b1;
      end
    end
  end

  // Crossbar output and credit return, both one cycle after the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xbFlit_q      <= '0;
      xbValid_q     <= 1'b0;
      creditValid_q <= 1'b0;
      creditVc_q    <= '0;
    end else begin
      xbValid_q <= anySaPop;
      if (anySaPop) xbFlit_q <= xbFlit_d;
      creditValid_q <= (FLOW_MODE != 0) && anyPop;
      if ((FLOW_MODE != 0) && anyPop) creditVc_q <= popVc;
    end
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      va_request_o[v]        = (state_q[v] == VA);
      sa_request_o[v]        = (state_q[v] == ACTIVE) && !empty[v];
      is_allocatable_vc_o[v] = (state_q[v] == IDLE) && empty[v];
    end
  end

  assign xb_flit_o          = xbFlit_q;
  assign xb_valid_o         = xbValid_q;
  assign sa_downstream_vc_o = downVc_q;
  assign out_port_o         = outPort_q;
  assign on_off_o           = onOff_q;
  assign credit_valid_o     = creditValid_q;
  assign credit_vc_o        = creditVc_q;
  assign error_o            = error_q;

endmodule

// File: tb/tb_input_port_vc_credit.sv
// Directed testbench for input_port_vc_credit. Two instances share the same
// stimulus: dutC runs in credit mode, dutO in on/off mode (BUFFER_SIZE=8,
// router at X=2, Y=2). Expected values are hand-computed constants.
module tb_input_port_vc_credit;
  import noc_params::*;

  logic            clk;
  logic            rst;
  flit_t           dataIn;
  logic            validFlit;
  logic [1:0][0:0] vaNewVc;
  logic [1:0]      vaValid;
  logic [1:0]      saSelVc;
  logic            saValid;

  flit_t           xbFlitC, xbFlitO;
  logic            xbValidC, xbValidO;
  logic [1:0]      vaReqC, vaReqO, saReqC, saReqO;
  logic [1:0][0:0] downVcC, downVcO;
  port_t [1:0]     outPortC, outPortO;
  logic [1:0]      onOffC, onOffO;
  logic            creditValidC, creditValidO;
  logic [0:0]      creditVcC, creditVcO;
  logic [1:0]      allocC, allocO, errorC, errorO;

  int checkCount = 0;
  int errorCount = 0;

  input_port_vc_credit #(.VC_NUM(2), .BUFFER_SIZE(8), .FLOW_MODE(1)) dutC (
    .clk(clk), .rst(rst), .data_i(dataIn), .valid_flit_i(validFlit),
    .va_new_vc_i(vaNewVc), .va_valid_i(vaValid), .sa_sel_vc_i(saSelVc),
    .sa_valid_i(saValid), .xb_flit_o(xbFlitC), .xb_valid_o(xbValidC),
    .va_request_o(vaReqC), .sa_request_o(saReqC),
    .sa_downstream_vc_o(downVcC), .out_port_o(outPortC), .on_off_o(onOffC),
    .credit_valid_o(creditValidC), .credit_vc_o(creditVcC),
    .is_allocatable_vc_o(allocC), .error_o(errorC));

  input_port_vc_credit #(.VC_NUM(2), .BUFFER_SIZE(8), .FLOW_MODE(0)) dutO (
    .clk(clk), .rst(rst), .data_i(dataIn), .valid_flit_i(validFlit),
    .va_new_vc_i(vaNewVc), .va_valid_i(vaValid), .sa_sel_vc_i(saSelVc),
    .sa_valid_i(saValid), .xb_flit_o(xbFlitO), .xb_valid_o(xbValidO),
    .va_request_o(vaReqO), .sa_request_o(saReqO),
    .sa_downstream_vc_o(downVcO), .out_port_o(outPortO), .on_off_o(onOffO),
    .credit_valid_o(creditValidO), .credit_vc_o(creditVcO),
    .is_allocatable_vc_o(allocO), .error_o(errorO));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic flit_t mkFlit(input flit_label_t lbl, input int vc,
                                   input int x, input int y, input int pl);
    flit_t f;
    f = '0;
    f.flit_label        = lbl;
    f.vc_id             = NOC_VC_SIZE'(vc);
    f.head_data.x_dest  = DEST_ADDR_SIZE_X'(x);
    f.head_data.y_dest  = DEST_ADDR_SIZE_Y'(y);
    f.head_data.head_pl = HEAD_PAYLOAD_SIZE'(pl);
    return f;
  endfunction

  // Drive one cycle of inputs, let the edge happen, sample point is #1 after.
  task automatic applyStimulus(input logic vf, input flit_t f,
                               input logic [1:0] vaV, input logic [1:0] vaNew,
                               input logic saV, input logic [1:0] saSel);
    validFlit  = vf;
    dataIn     = f;
    vaValid    = vaV;
    vaNewVc[0] = vaNew[0];
    vaNewVc[1] = vaNew[1];
    saValid    = saV;
    saSelVc    = saSel;
    @(posedge clk);
    #1;
    validFlit = 1'b0;
    dataIn    = '0;
    vaValid   = '0;
    vaNewVc   = '0;
    saValid   = 1'b0;
    saSelVc   = '0;
  endtask

  task automatic pushFlit(input flit_label_t lbl, input int vc, input int x, input int y);
    applyStimulus(1'b1, mkFlit(lbl, vc, x, y, 8'h5A), 2'b00, 2'b00, 1'b0, 2'b00);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 2'b00, 2'b00, 1'b0, 2'b00);
  endtask

  task automatic grantVa(input logic [1:0] vaV, input logic [1:0] vaNew);
    applyStimulus(1'b0, '0, vaV, vaNew, 1'b0, 2'b00);
  endtask

  task automatic popSel(input logic [1:0] sel);
    applyStimulus(1'b0, '0, 2'b00, 2'b00, 1'b1, sel);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    validFlit = 1'b0; dataIn = '0; vaValid = '0; vaNewVc = '0;
    saValid = 1'b0; saSelVc = '0;
    doReset();

    // Reset state
    checkOutput("rst_xb_valid", xbValidC, 0);
    checkOutput("rst_on_off_O", onOffO, 2'b11);
    checkOutput("rst_alloc", allocC, 2'b11);
    checkOutput("rst_error", errorC, 0);
    checkOutput("rst_out_port", outPortC, 0);
    checkOutput("rst_credit", creditValidC, 0);
    checkOutput("rst_va_req", vaReqC, 0);

    // HEADTAIL on VC1 toward EAST
    $display("[TB] single HEADTAIL on VC1");
    pushFlit(HEADTAIL, 1, 3, 2);
    checkOutput("t1_alloc_after_push", allocC, 2'b01);
    idleCycle();
    checkOutput("t1_va_req", vaReqC, 2'b10);
    checkOutput("t1_route_east", outPortC[1], EAST);
    grantVa(2'b10, 2'b00);
    checkOutput("t1_sa_req", saReqC, 2'b10);
    checkOutput("t1_va_req_clear", vaReqC, 2'b00);
    popSel(2'b10);
    checkOutput("t1_xb_valid", xbValidC, 1);
    checkOutput("t1_xb_vcid", xbFlitC.vc_id, 0);
    checkOutput("t1_xb_xdest", xbFlitC.head_data.x_dest, 3);
    checkOutput("t1_xb_label", xbFlitC.flit_label, HEADTAIL);
    checkOutput("t1_credit_valid", creditValidC, 1);
    checkOutput("t1_credit_vc", creditVcC, 1);
    checkOutput("t1_credit_O_off", creditValidO, 0);
    checkOutput("t1_idle_again", allocC, 2'b11);
    idleCycle();
    checkOutput("t1_xb_valid_drop", xbValidC, 0);
    checkOutput("t1_credit_drop", creditValidC, 0);

    // 4-flit packet on VC0 toward NORTH
    $display("[TB] 4-flit packet on VC0");
    pushFlit(HEAD, 0, 2, 0);
    pushFlit(BODY, 0, 0, 0);
    pushFlit(BODY, 0, 0, 0);
    pushFlit(TAIL, 0, 0, 0);
    checkOutput("t2_va_req", vaReqC, 2'b01);
    checkOutput("t2_route_north", outPortC[0], NORTH);
    grantVa(2'b01, 2'b01);
    checkOutput("t2_down_vc", downVcC[0], 1);
    checkOutput("t2_sa_req", saReqC, 2'b01);
    popSel(2'b01);
    checkOutput("t2_xb_valid0", xbValidC, 1);
    checkOutput("t2_xb_label0", xbFlitC.flit_label, HEAD);
    checkOutput("t2_xb_vcid0", xbFlitC.vc_id, 1);
    popSel(2'b01);
    checkOutput("t2_xb_valid1", xbValidC, 1);
    popSel(2'b01);
    checkOutput("t2_xb_valid2", xbValidC, 1);
    checkOutput("t2_not_alloc_yet", allocC[0], 0);
    popSel(2'b01);
    checkOutput("t2_xb_valid3", xbValidC, 1);
    checkOutput("t2_xb_label3", xbFlitC.flit_label, TAIL);
    checkOutput("t2_credit_vc", creditVcC, 0);
    checkOutput("t2_alloc_after_tail", allocC[0], 1);
    idleCycle();
    checkOutput("t2_xb_idle", xbValidC, 0);

    // On/off hysteresis on VC0 (OFF=6, ON=4)
    $display("[TB] on/off hysteresis");
    pushFlit(HEAD, 0, 2, 2);
    for (int i = 0; i < 4; i++) pushFlit(BODY, 0, 0, 0);
    checkOutput("t3_occ5_on", onOffO[0], 1);
    pushFlit(TAIL, 0, 0, 0);
    checkOutput("t3_occ6_off", onOffO[0], 0);
    checkOutput("t3_credit_mode_on", onOffC, 2'b11);
    checkOutput("t3_route_local", outPortC[0], LOCAL);
    grantVa(2'b01, 2'b00);
    popSel(2'b01);
    checkOutput("t3_occ5_still_off", onOffO[0], 0);
    popSel(2'b01);
    checkOutput("t3_occ4_on", onOffO[0], 1);
    for (int i = 0; i < 4; i++) popSel(2'b01);
    checkOutput("t3_drained_alloc", allocO, 2'b11);
    checkOutput("t3_no_error", errorO, 2'b00);

    // Overflow on VC1
    $display("[TB] overflow on VC1");
    pushFlit(HEAD, 1, 1, 2);
    for (int i = 0; i < 7; i++) pushFlit(BODY, 1, 0, 0);
    checkOutput("t4_full_no_err", errorC, 2'b00);
    checkOutput("t4_full_off", onOffO[1], 0);
    pushFlit(BODY, 1, 0, 0);
    checkOutput("t4_overflow_err", errorC, 2'b10);
    grantVa(2'b10, 2'b00);
    for (int i = 0; i < 8; i++) begin
      popSel(2'b10);
      checkOutput($sformatf("t4_drain_%0d", i), xbValidC, 1);
    end
    popSel(2'b10);
    checkOutput("t4_ninth_gone", xbValidC, 0);

    // Simultaneous push and pop on a full FIFO
    doReset();
    $display("[TB] push+pop on full VC1");
    pushFlit(HEAD, 1, 1, 2);
    for (int i = 0; i < 7; i++) pushFlit(BODY, 1, 0, 0);
    grantVa(2'b10, 2'b00);
    applyStimulus(1'b1, mkFlit(BODY, 1, 0, 0, 1), 2'b00, 2'b00, 1'b1, 2'b10);
    checkOutput("t4b_no_err", errorC, 2'b00);
    checkOutput("t4b_xb_valid", xbValidC, 1);
    idleCycle();
    checkOutput("t4b_still_off", onOffO[1], 0);
    pushFlit(BODY, 1, 0, 0);
    checkOutput("t4b_still_full", errorC, 2'b10);

    // Stray BODY and pop of empty VC
    doReset();
    $display("[TB] stray BODY and empty pop");
    pushFlit(BODY, 0, 0, 0);
    checkOutput("t5_no_err_yet", errorC, 2'b00);
    idleCycle();
    checkOutput("t5_body_err", errorC, 2'b01);
    checkOutput("t5_discard_credit", creditValidC, 1);
    checkOutput("t5_discard_credit_vc", creditVcC, 0);
    checkOutput("t5_stay_idle", vaReqC, 2'b00);
    checkOutput("t5_alloc", allocC, 2'b11);
    idleCycle();
    checkOutput("t5_credit_once", creditValidC, 0);
    popSel(2'b10);
    checkOutput("t5_empty_pop_err", errorC, 2'b11);
    checkOutput("t5_empty_pop_xb", xbValidC, 0);

    // Interleaved packets with asynchronous reset mid-stream
    doReset();
    $display("[TB] interleaved packets and async reset");
    pushFlit(HEAD, 0, 3, 1);
    pushFlit(HEAD, 1, 0, 3);
    pushFlit(BODY, 0, 0, 0);
    pushFlit(TAIL, 1, 0, 0);
    grantVa(2'b11, 2'b01);
    checkOutput("t6_route0", outPortC[0], EAST);
    checkOutput("t6_route1", outPortC[1], WEST);
    checkOutput("t6_sa_req", saReqC, 2'b11);
    popSel(2'b01);
    checkOutput("t6_xb_valid", xbValidC, 1);
    checkOutput("t6_xb_vcid", xbFlitC.vc_id, 1);
    checkOutput("t6_credit", creditValidC, 1);
    rst = 1'b1;
    #2;
    checkOutput("t6_async_xb", xbValidC, 0);
    checkOutput("t6_async_xb_flit", xbFlitC, 0);
    checkOutput("t6_async_credit", creditValidC, 0);
    checkOutput("t6_async_sa_req", saReqC, 2'b00);
    checkOutput("t6_async_alloc", allocC, 2'b11);
    checkOutput("t6_async_route", outPortC, 0);
    checkOutput("t6_async_on_off", onOffO, 2'b11);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      popSel((i % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput($sformatf("t6_no_credit_%0d", i), creditValidC, 0);
    end
    checkOutput("t6_no_xb", xbValidC, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
